// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types, size encodings and lane helpers for the data-memory
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 2'b11 falls through to the word case.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << addr_lo;
            SZ_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational store-data replication / lane mask and load-data
//            shift with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] st_wdata,
    input  logic [31:0] ld_word,
    output logic [31:0] st_wdata_rep,
    output logic [3:0]  st_lanes,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    assign st_lanes     = lane_mask(size, addr_lo);
    assign byte_shifted = ld_word >> {addr_lo, 3'b000};
    assign half_shifted = ld_word >> {addr_lo[1], 4'b0000};

    always_comb begin
        st_wdata_rep = st_wdata;
        ld_data      = ld_word;
        case (size)
            SZ_BYTE: begin
                st_wdata_rep = {4{st_wdata[7:0]}};
                ld_data      = is_unsigned ? {24'd0, byte_shifted[7:0]}
                                           : {{24{byte_shifted[7]}}, byte_shifted[7:0]};
            end
            SZ_HALF: begin
                st_wdata_rep = {2{st_wdata[15:0]}};
                ld_data      = is_unsigned ? {16'd0, half_shifted[15:0]}
                                           : {{16{half_shifted[15]}}, half_shifted[15:0]};
            end
            default: begin
                st_wdata_rep = st_wdata;
                ld_data      = ld_word;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Fixed-latency data-memory responder with valid/ready request and
//            response channels. Optional macro DMEM_MISALIGN_CHECK_EN enables
//            misaligned-access detection (rsp_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int AQ_W  = IDX_W + 2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       mem_rword;
    logic [31:0]       wdata_rep;
    logic [3:0]        lanes;
    logic [31:0]       load_ext;
    logic              misalign;
    logic              unused_addr_hi;

    // Upper address bits alias onto the same words.
    assign unused_addr_hi = ^req_addr[ADDR_W-1:AQ_W];
    assign idx            = addr_q[AQ_W-1:2];
    assign mem_rword      = mem[idx];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = misaligned(size_q, addr_q[1:0]);
`else
    assign misalign = 1'b0;
`endif

    dmem_lane_align u_align (
        .size         (size_q),
        .addr_lo      (addr_q[1:0]),
        .is_unsigned  (uns_q),
        .st_wdata     (wdata_q),
        .ld_word      (mem_rword),
        .st_wdata_rep (wdata_rep),
        .st_lanes     (lanes),
        .ld_data      (load_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AQ_W-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we  = we_q && !misalign;
                    rdata_d = (we_q || misalign) ? 32'd0 : load_ext;
                    err_d   = misalign;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

`default_nettype wire
